// File: rtl/riscv_axil_pkg.sv
// ----------------------------------------------------------------------------
// riscv_axil_pkg
//   Shared definitions for the RISC-V AXI4-lite master: AXI response codes,
//   access-protection encodings for instruction/data fetches, the master's
//   state enumeration and a helper that classifies a response as an error.
// ----------------------------------------------------------------------------
package riscv_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] INST_PROT = 3'b101;
    localparam logic [2:0] DATA_PROT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B,
        RESP,
        LOCKED
    } axil_state_t;

    // OKAY and EXOKAY are successes; SLVERR and DECERR are errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY: err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/riscv_axil_master_watchdog.sv
// ----------------------------------------------------------------------------
// riscv_axil_watchdog
//   Per-transaction outstanding-cycle counter for the AXI4-lite master.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   clear   : zero the counter (master idle)
//   enable  : a transaction is outstanding this cycle
//   expired : this is the LIMIT-th outstanding cycle (or later)
//   The counter saturates at LIMIT and never wraps.
// ----------------------------------------------------------------------------
module riscv_axil_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds the number of outstanding cycles already completed, so
    // reaching LIMIT-1 means the current cycle is the LIMIT-th one.
    assign expired = enable && (count_q >= CNT_LAST);

endmodule

// File: rtl/riscv_axil_master.sv
// ----------------------------------------------------------------------------
// riscv_axil_master
//   AXI4-lite master between the RISC-V core state machine and memory.
//   One read or write request at a time; every AXI output is a register.
//   Parameters: ADDR_W (address width), DATA_W (32 or 64), TIMEOUT_CYCLES
//   (outstanding-cycle limit before lockout, 0 disables the watchdog).
//   Ports:
//     clk, reset (async active-low)
//     req_valid/req_ready/req_write/req_instr/req_addr/req_wdata/req_wstrb
//                                   core request port
//     rsp_valid/rsp_data/rsp_err    one-cycle response pulse
//     rsp_timeout                   watchdog expired, sticky until reset
//     aw*/w*/b*/ar*/r*              AXI4-lite master channels
// ----------------------------------------------------------------------------
module riscv_axil_master
    import riscv_axil_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_instr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,

    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,

    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,

    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,

    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp
);

    localparam int unsigned STRB_W = DATA_W / 8;

    axil_state_t        state_q, state_d;

    logic               req_ready_q, req_ready_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         prot_q, prot_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         resp_q, resp_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic               ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic               wd_clear, wd_enable, wd_expired, wd_trip;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            riscv_axil_watchdog #(
                .LIMIT(TIMEOUT_CYCLES)
            ) u_wd (
                .clk    (clk),
                .reset  (reset),
                .clear  (wd_clear),
                .enable (wd_enable),
                .expired(wd_expired)
            );
        end else begin : g_no_wd
            assign wd_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        prot_d        = prot_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_data_d    = '0;
        rsp_timeout_d = rsp_timeout_q;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;
        wd_trip       = 1'b0;

        ar_hs = arvalid_q && arready;
        r_hs  = rready_q && rvalid;
        aw_hs = awvalid_q && awready;
        w_hs  = wvalid_q && wready;
        b_hs  = bready_q && bvalid;

        unique case (state_q)
            IDLE: begin
                wd_clear = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    prot_d  = req_instr ? INST_PROT : DATA_PROT;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    // Writes report zero data, so the read buffer starts cleared.
                    rdata_d = '0;
                    if (req_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_AW;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD_A;
                    end
                end
            end

            RD_A: begin
                wd_enable = 1'b1;
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    if (r_hs) begin
                        rready_d = 1'b0;
                        rdata_d  = rdata;
                        resp_d   = rresp;
                        state_d  = RESP;
                    end else begin
                        state_d = RD_D;
                    end
                end else if (wd_expired) begin
                    wd_trip = 1'b1;
                end
            end

            RD_D: begin
                wd_enable = 1'b1;
                if (r_hs) begin
                    rready_d = 1'b0;
                    rdata_d  = rdata;
                    resp_d   = rresp;
                    state_d  = RESP;
                end else if (wd_expired) begin
                    wd_trip = 1'b1;
                end
            end

            WR_AW: begin
                wd_enable = 1'b1;
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Count a handshake landing this cycle as already done so
                // bready follows the last one without an idle cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end else if (!aw_hs && !w_hs && wd_expired) begin
                    wd_trip = 1'b1;
                end
            end

            WR_B: begin
                wd_enable = 1'b1;
                if (b_hs) begin
                    bready_d = 1'b0;
                    resp_d   = bresp;
                    state_d  = RESP;
                end else if (wd_expired) begin
                    wd_trip = 1'b1;
                end
            end

            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = resp_is_err(resp_q);
                rsp_data_d  = rdata_q;
                state_d     = IDLE;
            end

            LOCKED: begin
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (wd_trip) begin
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = LOCKED;
        end

        // Registered ready: the core may only issue once the previous
        // response pulse has been seen.
        req_ready_d = (state_d == IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            prot_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata_q       <= '0;
            resp_q        <= RESP_OKAY;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            prot_q        <= prot_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rdata_q       <= rdata_d;
            resp_q        <= resp_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awprot  = prot_q;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = bready_q;
    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arprot  = prot_q;
    assign rready  = rready_q;

endmodule
